// File: rtl/adder_16_pkg.sv
// Shared constants and types for the 16-bit two-level carry-lookahead adder.
package adder_16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int GROUP_W   = 4;
    localparam int N_GROUPS  = WIDTH_DEF / GROUP_W;

    localparam logic [WIDTH_DEF-1:0] SUM_RST = 16'h0000;

endpackage

// File: rtl/adder_16_if.sv
// Operand/result bundle for adder_16; the master drives operands, the slave returns results.
interface adder_16_if;
    import adder_16_pkg::*;

    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic                 cin;
    logic [WIDTH_DEF-1:0] sum;
    logic                 c_n;
    logic                 c_n_minus_1;

    modport master (
        output a, b, cin,
        input  sum, c_n, c_n_minus_1
    );

    modport slave (
        input  a, b, cin,
        output sum, c_n, c_n_minus_1
    );

endinterface

// File: rtl/adder_16_cla_4.sv
// 4-bit carry-lookahead slice: sum bits, group generate/propagate and the carry into each bit.
module cla_4
    import adder_16_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               gg,
    output logic               gp,
    output logic [GROUP_W-1:0] c
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // c[i] is the carry into bit i, each fully expanded from ci
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

endmodule

// File: rtl/adder_16.sv
// 16-bit registered adder built from four cla_4 slices and a group-level lookahead unit.
module adder_16
    import adder_16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    output logic [WIDTH-1:0] sum,
    output logic             c_n,
    output logic             c_n_minus_1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n
);

    logic [N_GROUPS-1:0] gg;
    logic [N_GROUPS-1:0] gp;
    logic [N_GROUPS-1:0] c_grp;
    logic [GROUP_W-1:0]  c_int [N_GROUPS];

    logic [WIDTH-1:0]    sum_p0;
    logic                c14;
    logic                c15;
    logic                c16;
    logic                c_n_p0;
    logic                c_n_minus_1_p0;

    for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_slice
        cla_4 u_cla (
            .a  (a[gi*GROUP_W +: GROUP_W]),
            .b  (b[gi*GROUP_W +: GROUP_W]),
            .ci (c_grp[gi]),
            .s  (sum_p0[gi*GROUP_W +: GROUP_W]),
            .gg (gg[gi]),
            .gp (gp[gi]),
            .c  (c_int[gi])
        );
    end

    // Group carries c4, c8, c12 expanded directly from cin so no carry ripples between slices
    assign c_grp[0] = cin;
    assign c_grp[1] = gg[0] | (gp[0] & cin);
    assign c_grp[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign c_grp[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                    | (gp[2] & gp[1] & gp[0] & cin);

    assign c16 = gg[3] | (gp[3] & c_grp[3]);

    // Carry into bit 15 made explicit so the sign-overflow pair is observable
    assign c14 = c_int[3][2];
    assign c15 = (a[14] & b[14]) | ((a[14] ^ b[14]) & c14);

    assign c_n_p0         = c16;
    assign c_n_minus_1_p0 = c15;

    // p0 -> output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum         <= WIDTH'(SUM_RST);
            c_n         <= 1'b0;
            c_n_minus_1 <= 1'b0;
        end else begin
            sum         <= sum_p0;
            c_n         <= c_n_p0;
            c_n_minus_1 <= c_n_minus_1_p0;
        end
    end

endmodule

// File: tb/tb_adder_16.sv
// Directed and random checks of adder_16 against a plain 17-bit reference sum.
module tb_adder_16;
    import adder_16_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [15:0] exp_sum;
    logic        exp_cn;
    logic        exp_cn1;

    adder_16_if bus ();

    adder_16 #(.WIDTH(16)) dut (
        .sum         (bus.sum),
        .c_n         (bus.c_n),
        .c_n_minus_1 (bus.c_n_minus_1),
        .a           (bus.a),
        .b           (bus.b),
        .cin         (bus.cin),
        .clk         (clk),
        .rst_n       (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] es,
                             input logic ecn, input logic ecn1);
        check({tag, ".sum"}, bus.sum, es);
        check({tag, ".c_n"}, {15'd0, bus.c_n}, {15'd0, ecn});
        check({tag, ".c_n_minus_1"}, {15'd0, bus.c_n_minus_1}, {15'd0, ecn1});
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cn;
        logic        cn1;
    } vec_t;

    vec_t vecs [14];

    task automatic run_vec(input string tag, input vec_t v);
        @(negedge clk);
        bus.a   = v.a;
        bus.b   = v.b;
        bus.cin = v.cin;
        @(posedge clk);
        #1;
        check_out(tag, v.s, v.cn, v.cn1);
    endtask

    task automatic ref_add(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           output logic [15:0] s, output logic cn, output logic cn1);
        logic [16:0] full;
        logic [15:0] low;
        full = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        low  = {1'b0, a[14:0]} + {1'b0, b[14:0]} + {15'd0, ci};
        s    = full[15:0];
        cn   = full[16];
        cn1  = low[15];
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0]  = '{16'hFFFD, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[1]  = '{16'h8000, 16'h0000, 1'b1, 16'h8001, 1'b0, 1'b0};
        vecs[2]  = '{16'h0004, 16'h0000, 1'b1, 16'h0005, 1'b0, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        vecs[6]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'hC000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[12] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[13] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst_n   = 1'b0;
        bus.a   = 16'hABCD;
        bus.b   = 16'h1357;
        bus.cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Outputs must not follow input changes between edges
        bus.a   = 16'hFFFF;
        bus.b   = 16'hFFFF;
        bus.cin = 1'b1;
        #2;
        check_out("hold", 16'h1000, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, then first result after release
        run_vec("pre_rst", vecs[7]);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_held", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_rst", 16'h2345, 1'b0, 1'b0);

        exp_sum = 16'h2345;
        exp_cn  = 1'b0;
        exp_cn1 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            @(negedge clk);
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            bus.a   = ra;
            bus.b   = rb;
            bus.cin = rc;
            #1;
            check("rnd_prev.sum", bus.sum, exp_sum);
            ref_add(ra, rb, rc, exp_sum, exp_cn, exp_cn1);
            @(posedge clk);
            #1;
            check_out("rnd", exp_sum, exp_cn, exp_cn1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
